// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built on a bank of JK flip-flops.
// The target next state is turned into per-bit J/K excitation, and the flops
// apply standard JK semantics on the rising clock edge.
// Optional build macro: JK_SATURATE_EN (saturate at the range ends instead of wrapping).
module jk_mod_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J_out,
    output logic [WIDTH-1:0] K_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the load range check.
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] target;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (q_q == MaxVal);
    assign at_bottom = (q_q == '0);

    // Target next state: load beats count enable, which beats hold.
    always_comb begin
        target = q_q;
        if (load) begin
            target = ({1'b0, load_val} < ModExt) ? load_val : '0;
        end else if (en) begin
            if (q_q > MaxVal) begin
                // Unreachable illegal state recovers to zero in either direction.
                target = '0;
            end else if (up) begin
`ifdef JK_SATURATE_EN
                target = at_top ? q_q : q_q + WIDTH'(1);
`else
                target = at_top ? '0 : q_q + WIDTH'(1);
`endif
            end else begin
`ifdef JK_SATURATE_EN
                target = at_bottom ? q_q : q_q - WIDTH'(1);
`else
                target = at_bottom ? MaxVal : q_q - WIDTH'(1);
`endif
            end
        end
    end

    // JK excitation with don't-cares resolved to 0, so J and K are never both set.
    always_comb begin
        J_out = ~q_q & target;
        K_out = q_q & ~target;
    end

    // Per-bit JK flop behaviour, including toggle for robustness.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case ({J_out[i], K_out[i]})
                2'b10:   q_d[i] = 1'b1;
                2'b01:   q_d[i] = 1'b0;
                2'b11:   q_d[i] = ~q_q[i];
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    // JK flop bank state register.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal count flags the cycle whose edge wraps (or holds at a saturated end).
    always_comb begin
        tc = en & ~load & ((up & at_top) | (~up & at_bottom));
    end

    assign Q = q_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed table, corner sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_jk_mod_counter;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MODULUS = 10;
    localparam int          Mask    = (1 << WIDTH) - 1;

    logic             clk;
    logic             async_reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J_out;
    logic [WIDTH-1:0] K_out;
    logic             tc;

    int checks = 0;
    int errors = 0;
    int mq     = 0;   // model count

    jk_mod_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .en          (en),
        .up          (up),
        .load        (load),
        .load_val    (load_val),
        .Q           (Q),
        .J_out       (J_out),
        .K_out       (K_out),
        .tc          (tc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit ld;
        bit e;
        bit u;
        int lv;
        int j;
        int k;
        bit t;
        int q;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_next(input int q, input bit ld, input bit e, input bit u,
                                      input int lv);
        if (ld) return (lv < int'(MODULUS)) ? lv : 0;
        if (!e) return q;
        if (q >= int'(MODULUS)) return 0;
`ifdef JK_SATURATE_EN
        if (u) return (q == int'(MODULUS) - 1) ? q : q + 1;
        return (q == 0) ? 0 : q - 1;
`else
        if (u) return (q + 1) % int'(MODULUS);
        return (q + int'(MODULUS) - 1) % int'(MODULUS);
`endif
    endfunction

    function automatic bit model_tc(input int q, input bit ld, input bit e, input bit u);
        return e && !ld && ((u && q == int'(MODULUS) - 1) || (!u && q == 0));
    endfunction

    // Called 1 time unit after a rising edge: drive, check comb outputs, clock, check Q.
    task automatic apply(input bit ld, input bit e, input bit u, input int lv,
                         input string tag);
        int n;
        load     = ld;
        en       = e;
        up       = u;
        load_val = WIDTH'(lv);
        #1;
        n = model_next(mq, ld, e, u, lv & Mask);
        chk({tag, "_tc"}, int'(tc), int'(model_tc(mq, ld, e, u)));
        chk({tag, "_j"}, int'(J_out), (~mq & n) & Mask);
        chk({tag, "_k"}, int'(K_out), (mq & ~n) & Mask);
        @(posedge clk);
        #1;
        mq = n;
        chk({tag, "_q"}, int'(Q), mq);
    endtask

    initial begin
        vec_t tbl[$];

        async_reset = 1'b1;
        en          = 1'b1;
        up          = 1'b0;
        load        = 1'b0;
        load_val    = '0;

        // Reset state: Q cleared, tc follows its equation against Q=0.
        #3;
        chk("reset_q", int'(Q), 0);
        chk("reset_tc_down", int'(tc), 1);
        en = 1'b0;
        #1;
        chk("reset_tc_idle", int'(tc), 0);
        @(posedge clk);
        #1;
        chk("reset_hold_q", int'(Q), 0);
        async_reset = 1'b0;
        @(posedge clk);
        #1;
        mq = 0;

`ifndef JK_SATURATE_EN
        // Directed table: {ld, en, up, load_val, J, K, tc, Q after edge}
        tbl.push_back('{1, 0, 1,  9, 9, 0, 0, 9});   // load 9
        tbl.push_back('{0, 1, 1,  0, 0, 9, 1, 0});   // up wrap 9 -> 0
        tbl.push_back('{0, 1, 0,  0, 9, 0, 1, 9});   // down wrap 0 -> 9
        tbl.push_back('{1, 1, 1,  3, 2, 8, 0, 3});   // load beats en
        tbl.push_back('{1, 1, 1,  7, 4, 0, 0, 7});   // Q=3 load 7
        tbl.push_back('{1, 0, 1, 12, 0, 7, 0, 0});   // out-of-range clamps to 0
        tbl.push_back('{1, 0, 1,  5, 5, 0, 0, 5});
        for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 5});   // hold
        tbl.push_back('{0, 1, 1,  0, 2, 1, 0, 6});
        tbl.push_back('{0, 1, 0,  0, 1, 2, 0, 5});
        tbl.push_back('{1, 0, 0, 15, 0, 5, 0, 0});
        tbl.push_back('{0, 0, 0,  0, 0, 0, 0, 0});   // disabled at zero: no tc
        tbl.push_back('{0, 1, 1,  0, 1, 0, 0, 1});

        foreach (tbl[i]) begin
            load     = tbl[i].ld;
            en       = tbl[i].e;
            up       = tbl[i].u;
            load_val = WIDTH'(tbl[i].lv);
            #1;
            chk($sformatf("tbl%0d_j", i), int'(J_out), tbl[i].j);
            chk($sformatf("tbl%0d_k", i), int'(K_out), tbl[i].k);
            chk($sformatf("tbl%0d_tc", i), int'(tc), int'(tbl[i].t));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_q", i), int'(Q), tbl[i].q);
            mq = tbl[i].q;
        end
`endif

        // Reset mid-count: count to 6, pulse reset between edges.
        apply(1, 0, 1, 0, "pre_mid");
        for (int i = 0; i < 6; i++) apply(0, 1, 1, 0, "count_up");
        chk("mid_q6", int'(Q), 6);
        #2;
        async_reset = 1'b1;
        #1;
        chk("mid_reset_immediate", int'(Q), 0);
        @(posedge clk);
        #1;
        chk("mid_reset_held", int'(Q), 0);
        async_reset = 1'b0;
        mq = 0;
        apply(0, 1, 1, 0, "post_reset");
        chk("post_reset_q1", int'(Q), 1);

`ifdef JK_SATURATE_EN
        apply(1, 0, 1, 9, "sat_load9");
        for (int i = 0; i < 3; i++) begin
            load = 1'b0; en = 1'b1; up = 1'b1;
            #1;
            chk("sat_up_tc", int'(tc), 1);
            chk("sat_up_jk", int'(J_out | K_out), 0);
            @(posedge clk);
            #1;
            chk("sat_up_q", int'(Q), 9);
        end
        apply(1, 0, 0, 0, "sat_load0");
        for (int i = 0; i < 3; i++) begin
            load = 1'b0; en = 1'b1; up = 1'b0;
            #1;
            chk("sat_dn_tc", int'(tc), 1);
            chk("sat_dn_jk", int'(J_out | K_out), 0);
            @(posedge clk);
            #1;
            chk("sat_dn_q", int'(Q), 0);
        end
        mq = 0;
`endif

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            bit ld;
            bit e;
            bit u;
            int lv;
            ld = ($urandom_range(0, 4) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) != 0;
            lv = int'($urandom_range(0, Mask));
            apply(ld, e, u, lv, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Up/down modulo-N counter whose state register is a bank of JK flip-flops.
- Next state is produced by JK excitation logic: the block computes the J/K pair each flop needs to reach the target state, then applies standard JK semantics on the clock edge.
- The block is the driver side of the JK flop interface. It turns a desired next state into J/K inputs and closes the loop through the flops.
- It is the team's building block for counter and sequencer exercises. It also exports J/K so benches can check excitation directly.

Parameters:
- WIDTH, 4, bit width of count state, J/K buses and load value.
- MODULUS, 10, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- async_reset  input  1  asynchronous, active-high reset; clears all state immediately.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_val  input  WIDTH  value loaded when load=1.
- Q  output  WIDTH  current count (JK flop bank outputs).
- J_out  output  WIDTH  J excitation applied this cycle (combinational).
- K_out  output  WIDTH  K excitation applied this cycle (combinational).
- tc  output  1  terminal count (combinational).

Behaviour:
- Reset:
  - async_reset=1 forces Q=0 with no dependence on clk, and holds it while asserted.
  - With Q=0, tc follows its combinational equation against Q=0.
  - Reset release takes effect at the next rising edge.
  - Reset asserted mid-count aborts the count; no partial update.
- Target next state N, priority load > en > hold:
  - load=1: N = load_val if load_val < MODULUS, else N = 0. Out-of-range loads are clamped to 0 and never stored.
  - load=0, en=1, up=1: N = Q+1, wrapping MODULUS-1 -> 0.
  - load=0, en=1, up=0: N = Q-1, wrapping 0 -> MODULUS-1.
  - load=0, en=0: N = Q.
- Excitation, per bit i, with don't-cares resolved to 0:
  - J_out[i] = ~Q[i] & N[i]
  - K_out[i] = Q[i] & ~N[i]
  - Consequence: a bit never sees J=K=1; hold gives J=K=0 on every bit.
- Flop update, per bit on the rising edge of clk:
  - J=1, K=0: set to 1.
  - J=0, K=1: clear to 0.
  - J=0, K=0: hold.
  - J=1, K=1: toggle. This case is supported for robustness but is unreachable from the excitation equations above.
- Latency: Q equals N one clock after the inputs are sampled.
- tc = en & ~load & ((up & Q==MODULUS-1) | (~up & Q==0)). It is high in the cycle whose edge wraps the count.
- Simultaneous load and en: load wins, and tc=0.
- Power-of-two MODULUS (for example 16 with WIDTH=4): wrap arithmetic is natural modulo 2**WIDTH with identical results.
- Illegal state: Q >= MODULUS is unreachable. An implementation must still define it; the next count from such a Q is 0 in both directions.

Optional Feature:
- Macro: JK_SATURATE_EN.
- When defined:
  - The counter saturates instead of wrapping: up at MODULUS-1 holds, down at 0 holds. J_out=K_out=0 in those cycles.
  - tc keeps the same equation and flags the saturated boundary each cycle it is held.
- When undefined: wrap behaviour exactly as specified in Behaviour.

Test Plan:
- Reset mid-count: WIDTH=4, MODULUS=10, up-count to Q=6, pulse async_reset between edges -> Q=0 immediately, before the next edge; after release with en=1, up=1, the next edge gives Q=1.
- Up wrap: Q=9, en=1, up=1 -> tc=1, J_out=0000, K_out=1001; next edge Q=0.
- Down wrap: Q=0, en=1, up=0 -> tc=1, J_out=1001, K_out=0000; next edge Q=9.
- Load priority and clamp:
  - Q=3, load=1, load_val=7, en=1 -> tc=0; next edge Q=7.
  - Then load_val=12 -> next edge Q=0.
- Hold: en=0, load=0 for 5 cycles at Q=5 -> Q stays 5; J_out=K_out=0000 throughout.
- JK_SATURATE_EN build: Q=9, en=1, up=1 for 3 edges -> Q stays 9, tc=1 each cycle; down from Q=0 -> Q stays 0.
